// File: rtl/mini_alu_pipe_pkg.sv
// rtl/mini_alu_pipe_pkg.sv - opcode encodings shared by the mini ALU core and its bench
package mini_alu_pipe_pkg;

    localparam int OPC_BASE_W = 4;

    typedef logic [OPC_BASE_W-1:0] opcode_t;

    localparam opcode_t OP_NOP  = 4'h0;
    localparam opcode_t OP_STO  = 4'h1;
    localparam opcode_t OP_ADD  = 4'h2;
    localparam opcode_t OP_SUB  = 4'h3;
    localparam opcode_t OP_LED  = 4'h4;
    localparam opcode_t OP_JMP  = 4'h5;
    localparam opcode_t OP_BLE  = 4'h6;
    localparam opcode_t OP_SMUL = 4'h7;
    localparam opcode_t OP_AND  = 4'h8;
    localparam opcode_t OP_OR   = 4'h9;
    localparam opcode_t OP_BNE  = 4'hA;

endpackage

// File: rtl/mini_alu_pipe_seq_mul.sv
// rtl/mini_alu_pipe_seq_mul.sv - shift-add multiplier, one multiplier bit per cycle, truncated product
module seq_mul #(
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iStart,
    input  logic [DATA_W-1:0] iA,
    input  logic [DATA_W-1:0] iB,
    output logic              oBusy,
    output logic              oDone,
    output logic [DATA_W-1:0] oP
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_next;
    logic [CNT_W-1:0]  cnt;
    logic              busy;

    // oP already includes the final step so the result can be written on the last busy cycle
    always_comb begin
        acc_next = acc + (b[0] ? a : '0);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            busy <= 1'b0;
            cnt  <= '0;
            a    <= '0;
            b    <= '0;
            acc  <= '0;
        end else if (busy) begin
            acc <= acc_next;
            a   <= a << 1;
            b   <= b >> 1;
            cnt <= cnt + CNT_W'(1);
            if (oDone) begin
                busy <= 1'b0;
            end
        end else if (iStart) begin
            a    <= iA;
            b    <= iB;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
        end
    end

    assign oBusy = busy;
    assign oDone = busy && (cnt == CNT_W'(DATA_W - 1));
    assign oP    = acc_next;

endmodule

// File: rtl/mini_alu_pipe.sv
// rtl/mini_alu_pipe.sv - two-stage fetch/execute mini ALU with forwarding; MINI_ALU_SMUL_EN adds SMUL
module mini_alu_pipe
    import mini_alu_pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int OPC_W  = 4,
    parameter int IP_W   = 16,
    parameter int LED_W  = 8
) (
    input  logic                        Clock,
    input  logic                        Reset,
    output logic [IP_W-1:0]             oIP,
    input  logic [OPC_W+3*ADDR_W-1:0]   iInstruction,
    output logic [LED_W-1:0]            oLed,
    output logic                        oBusy
);

    localparam int IW = OPC_W + 3*ADDR_W;

    logic [OPC_W-1:0]  f_op;
    logic [ADDR_W-1:0] f_dst, f_src1, f_src0;

    assign f_op   = iInstruction[IW-1 -: OPC_W];
    assign f_dst  = iInstruction[3*ADDR_W-1 -: ADDR_W];
    assign f_src1 = iInstruction[2*ADDR_W-1 -: ADDR_W];
    assign f_src0 = iInstruction[ADDR_W-1:0];

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd0, rd1;
    logic [OPC_W-1:0]  ex_op;
    logic [ADDR_W-1:0] ex_dst, ex_src1, ex_src0;
    logic [IP_W-1:0]   ip_cnt;
    logic [LED_W-1:0]  led;
    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_addr;
    logic [DATA_W-1:0] fwd_data;

    logic [DATA_W-1:0] d0, d1, imm, wr_data;
    logic              wr_en, led_en, branch, stall;
    opcode_t           op;

    assign d0  = (fwd_valid && fwd_addr == ex_src0) ? fwd_data : rd0;
    assign d1  = (fwd_valid && fwd_addr == ex_src1) ? fwd_data : rd1;
    assign imm = DATA_W'({ex_src1, ex_src0});

    // opcodes wider than the defined set never alias onto a real op
    assign op = ((ex_op >> OPC_BASE_W) == '0) ? opcode_t'(ex_op) : OP_NOP;

`ifdef MINI_ALU_SMUL_EN
    logic              smul_go, mul_start, mul_busy, mul_done;
    logic [DATA_W-1:0] mul_p;

    // SMUL holds fetch from its first execute cycle until the product is written
    assign stall     = smul_go && !mul_done;
    assign mul_start = smul_go && !mul_busy;
    assign oBusy     = mul_busy;

    seq_mul #(.DATA_W(DATA_W)) u_mul (
        .Clock  (Clock),
        .Reset  (Reset),
        .iStart (mul_start),
        .iA     (d1),
        .iB     (d0),
        .oBusy  (mul_busy),
        .oDone  (mul_done),
        .oP     (mul_p)
    );
`else
    assign stall = 1'b0;
    assign oBusy = 1'b0;
`endif

    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        led_en  = 1'b0;
        branch  = 1'b0;
`ifdef MINI_ALU_SMUL_EN
        smul_go = 1'b0;
`endif
        case (op)
            OP_STO: begin wr_en = 1'b1; wr_data = imm;     end
            OP_ADD: begin wr_en = 1'b1; wr_data = d1 + d0; end
            OP_SUB: begin wr_en = 1'b1; wr_data = d1 - d0; end
            OP_AND: begin wr_en = 1'b1; wr_data = d1 & d0; end
            OP_OR:  begin wr_en = 1'b1; wr_data = d1 | d0; end
            OP_LED: led_en = 1'b1;
            OP_JMP: branch = 1'b1;
            OP_BLE: branch = (d1 <= d0);
            OP_BNE: branch = (d1 != d0);
`ifdef MINI_ALU_SMUL_EN
            OP_SMUL: begin
                smul_go = 1'b1;
                wr_en   = mul_done;
                wr_data = mul_p;
            end
`endif
            default: ;
        endcase
    end

    // taken branches redirect the fetch in the same cycle, so there is no delay slot
    assign oIP  = branch ? IP_W'(ex_dst) : ip_cnt;
    assign oLed = led;

    always_ff @(posedge Clock) begin
        rd0 <= mem[f_src0];
        rd1 <= mem[f_src1];
        if (wr_en && !Reset) begin
            mem[ex_dst] <= wr_data;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ip_cnt    <= '0;
            ex_op     <= OPC_W'(OP_NOP);
            ex_dst    <= '0;
            ex_src1   <= '0;
            ex_src0   <= '0;
            led       <= '0;
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
        end else begin
            if (!stall) begin
                ip_cnt  <= oIP + IP_W'(1);
                ex_op   <= f_op;
                ex_dst  <= f_dst;
                ex_src1 <= f_src1;
                ex_src0 <= f_src0;
            end
            if (led_en) begin
                led <= d1[LED_W-1:0];
            end
            if (wr_en) begin
                fwd_valid <= 1'b1;
                fwd_addr  <= ex_dst;
                fwd_data  <= wr_data;
            end
        end
    end

endmodule
